des_round_sequencer: RTL and testbench
======================================

// Module: des_round_sequencer
// PURPOSE
//  Iterative DES controller: accepts a 64-bit key and a direction, sequences 16 rounds over a shared
//  single-round datapath (one round per cycle) and issues the per-round 48-bit subkey.
//  Holds the C/D key-schedule registers (PC-1 on load, rotate per round, PC-2 to the subkey).
//  Sits between the host handshake and the round datapath (IP, round function, FP).
//  Bit numbering follows the DES standard: key[63] is DES bit 1, and key[0] is DES bit 64 (parity, ignored).
// PARAMETERS
//  NUM_ROUNDS   16   rounds per block; fixed at 16 for DES (other values are unsupported)
//  IDX_W        4    width of round_idx
// PORTS
//  clk          in   1   single clock; all state updates on the rising edge
//  rst_n        in   1   asynchronous active-low reset
//  start_valid  in   1   request: key and decrypt are valid
//  start_ready  out  1   1 only in IDLE; request accepted when start_valid & start_ready
//  key          in   64  DES key, sampled on acceptance
//  decrypt      in   1   0 = encrypt (subkeys K1..K16), 1 = decrypt (subkeys K16..K1); sampled on acceptance
//  block_load   out  1   combinational start_valid & start_ready; datapath loads IP(block) this cycle
//  round_en     out  1   datapath performs one round this cycle
//  round_idx    out  4   0..15 while round_en=1, else 0
//  subkey       out  48  PC-2(C,D) for the current round; 0 when round_en=0
//  last_round   out  1   round_en & round_idx==15; datapath omits the L/R swap
//  done_valid   out  1   result ready at the datapath output; held until done_ready
//  done_ready   in   1   consumer accepts the result
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, C=D=0, round counter=0; every output is 0 (start_ready included).
//   start_ready rises at the first clk edge after rst_n deasserts. Reset mid-operation aborts the block:
//   no done_valid is produced.
//  FSM states: IDLE -> ROUND (on acceptance) -> DONE (after round_idx 15 completes) -> IDLE (on done_ready).
//   From DONE, the next start is accepted no earlier than the cycle after the return to IDLE.
//  Acceptance at cycle T: C,D <= PC-1(key) halves, pre-rotated for the first round
//   (encrypt: rotate left 1; decrypt: no rotation). dir <= decrypt. Counter <= 0.
//  Cycles T+1..T+16: round_en=1 and round_idx=k. subkey=PC-2({C,D}) is taken directly from the registers,
//   with no extra latency. At each edge in ROUND, C/D advance for round k+1:
//   encrypt: rotate left by S[k+1]; decrypt: rotate right by S[15-k].
//   S = {1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1}. Rotation is 28-bit circular per half.
//   After round 15, C/D need not return to their initial value.
//  T+17: done_valid=1 (a fixed 17-cycle latency from acceptance), held with stable outputs until
//   done_ready=1. done_valid & done_ready in the same cycle -> IDLE at the next edge.
//   done_ready while not done_valid: ignored.
//  start_valid while busy: ignored (start_ready=0); key/decrypt changes after acceptance have no effect.
//  Counter: IDX_W bits. The transition ROUND->DONE is decided on counter==15; wrap-around to 0 never drives round_en.
// CONFIGURATION
//  DES_ROUND_STALL_EN defined: adds input round_stall (1 bit). While round_stall=1 in ROUND:
//   round_en=0, subkey=0, and C/D, counter and state hold, so the round is re-issued with the same
//   round_idx/subkey once stall drops. In IDLE/DONE it is ignored. Latency = 17 + number of stalled ROUND cycles.
//  Not defined: the port does not exist and the latency is fixed at 17 cycles.
// TESTING
//  1 Encrypt, key=64'h133457799BBCDFF1: handshake at T -> T+1 subkey=48'h1B02EFFC7072 idx 0;
//    T+2 subkey=48'h79AED9DBC9E5; T+16 subkey=48'hCB3D8B0E17F5, last_round=1; done_valid at T+17.
//  2 Decrypt, same key -> idx 0 subkey=48'hCB3D8B0E17F5, idx 15 subkey=48'h1B02EFFC7072;
//    the full sequence is the reverse of scenario 1.
//  3 Backpressure: hold done_ready=0 for 5 cycles after done_valid -> done_valid stays 1, start_ready=0,
//    and a start_valid pulse is ignored. Raise done_ready -> IDLE; the next start is accepted with
//    block_load=1 in that cycle.
//  4 Reset mid-run: drop rst_n asynchronously during round_idx=7 -> all outputs 0 immediately.
//    After release, start_ready=1 one edge later and no done_valid is produced; a new run matches scenario 1.
//  5 Back-to-back: start_valid held 1 with done_ready tied 1 -> acceptances 18 cycles apart,
//    with 16 round_en cycles per block.
//  6 DES_ROUND_STALL_EN: stall at idx 3 for 2 cycles -> idx 3 subkey is re-issued unchanged; done_valid at T+19.

Source files
------------

// File: rtl/des_round_sequencer_if.sv
// Handshake/round-control bundle between the DES host, des_round_sequencer and the round datapath.
// The round_stall signal exists only when DES_ROUND_STALL_EN is defined.
interface des_round_sequencer_if #(
  parameter int IDX_W = 4
);
  logic             start_valid;
  logic             start_ready;
  logic [63:0]      key;
  logic             decrypt;
  logic             block_load;
  logic             round_en;
  logic [IDX_W-1:0] round_idx;
  logic [47:0]      subkey;
  logic             last_round;
  logic             done_valid;
  logic             done_ready;
  logic             busy;
`ifdef DES_ROUND_STALL_EN
  logic             round_stall;
`endif

  // Host/datapath side.
  modport master (
`ifdef DES_ROUND_STALL_EN
    output round_stall,
`endif
    output start_valid, key, decrypt, done_ready,
    input  start_ready, block_load, round_en, round_idx, subkey, last_round, done_valid, busy
  );

  // Sequencer side.
  modport slave (
`ifdef DES_ROUND_STALL_EN
    input  round_stall,
`endif
    input  start_valid, key, decrypt, done_ready,
    output start_ready, block_load, round_en, round_idx, subkey, last_round, done_valid, busy
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Iterative DES controller: one round per cycle over a shared datapath, C/D key schedule and subkey.
// Optional DES_ROUND_STALL_EN adds round_stall, which freezes the current round while high.
module des_round_sequencer #(
  parameter int NUM_ROUNDS = 16,
  parameter int IDX_W      = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  des_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROUNDS - 1);
  // Bit r set when key-schedule round r+1 shifts by one position instead of two.
  localparam logic [15:0] SHIFT_ONE = 16'h8103;

  localparam logic [5:0] PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam logic [5:0] PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // DES bit n of the key lives at key[64-n]; CD bit n at cd[56-n].
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(7'd64 - 7'(PC1_TAB[6'(i)]))];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(7'd56 - 7'(PC2_TAB[6'(i)]))];
    return r;
  endfunction

  function automatic logic [27:0] rotl(input logic [27:0] x, input logic by_one);
    return by_one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

  function automatic logic [27:0] rotr(input logic [27:0] x, input logic by_one);
    return by_one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction

  state_e           state_q, state_d;
  logic [27:0]      c_half_q, c_half_d;
  logic [27:0]      d_half_q, d_half_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             armed_q, armed_d;

  logic             stall;
  logic             start_ready;
  logic             accept;
  logic             round_en;
  logic             step_one;
  logic [55:0]      key_cd;
  logic [IDX_W-1:0] cnt_inc;

`ifdef DES_ROUND_STALL_EN
  assign stall = bus.round_stall;
`else
  assign stall = 1'b0;
`endif

  assign key_cd      = pc1(bus.key);
  assign cnt_inc     = cnt_q + 1'b1;
  // armed_q keeps start_ready low through reset and for the first edge after release.
  assign start_ready = armed_q && (state_q == ST_IDLE);
  assign accept      = bus.start_valid && start_ready;
  assign round_en    = (state_q == ST_ROUND) && !stall;
  // Encrypt applies the shift of the next round; decrypt undoes the shift of round 16-k.
  assign step_one    = dir_q ? SHIFT_ONE[~cnt_q] : SHIFT_ONE[cnt_inc];

  // NOTE: every variable gets its hold value first so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    c_half_d = c_half_q;
    d_half_d = d_half_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    armed_d  = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d  = ST_ROUND;
          dir_d    = bus.decrypt;
          cnt_d    = '0;
          c_half_d = bus.decrypt ? key_cd[55:28] : rotl(key_cd[55:28], 1'b1);
          d_half_d = bus.decrypt ? key_cd[27:0]  : rotl(key_cd[27:0], 1'b1);
        end
      end
      ST_ROUND: begin
        if (!stall) begin
          cnt_d    = cnt_inc;
          c_half_d = dir_q ? rotr(c_half_q, step_one) : rotl(c_half_q, step_one);
          d_half_d = dir_q ? rotr(d_half_q, step_one) : rotl(d_half_q, step_one);
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.done_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values, matching hardware.
  // NOTE: C/D are reset even though each acceptance reloads them, so subkey never exposes stale key material.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      c_half_q <= '0;
      d_half_q <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_half_q <= c_half_d;
      d_half_q <= d_half_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      armed_q  <= armed_d;
    end
  end

  assign bus.start_ready = start_ready;
  assign bus.block_load  = accept;
  assign bus.round_en    = round_en;
  assign bus.round_idx   = round_en ? cnt_q : '0;
  assign bus.subkey      = round_en ? pc2({c_half_q, d_half_q}) : '0;
  assign bus.last_round  = round_en && (cnt_q == LAST_IDX);
  assign bus.done_valid  = (state_q == ST_DONE);
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_round_sequencer.sv
// Self-checking bench for des_round_sequencer: directed spec vectors plus random keys checked
// against a textbook DES key-schedule model (builds with or without DES_ROUND_STALL_EN).
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  des_round_sequencer_if bus_if ();
  des_round_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));

  int n_checks = 0;
  int n_fail   = 0;

  localparam int PC1[56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2[48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS[16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam logic [63:0] SPEC_KEY = 64'h133457799BBCDFF1;

  logic [47:0] exp_sk   [16];
  logic [47:0] const_sk [16];
  bit          const_vld[16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Standard DES key schedule: C0/D0 from PC-1, cumulative left shifts, PC-2 per round.
  task automatic compute_model(input logic [63:0] k, input logic dec);
    logic [27:0] c, d;
    logic [47:0] ks;
    logic [47:0] enc[16];
    for (int i = 0; i < 28; i++) begin
      c[5'(27 - i)] = k[6'(64 - PC1[i])];
      d[5'(27 - i)] = k[6'(64 - PC1[i + 28])];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      for (int j = 0; j < 48; j++) ks[6'(47 - j)] = {c, d}[6'(56 - PC2[j])];
      enc[r] = ks;
    end
    for (int r = 0; r < 16; r++) exp_sk[r] = dec ? enc[15 - r] : enc[r];
  endtask

  task automatic clear_consts();
    for (int i = 0; i < 16; i++) begin
      const_vld[i] = 1'b0;
      const_sk[i]  = '0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start_ready"}, bus_if.start_ready, 0);
    check({tag, "_block_load"},  bus_if.block_load,  0);
    check({tag, "_round_en"},    bus_if.round_en,    0);
    check({tag, "_round_idx"},   bus_if.round_idx,   0);
    check({tag, "_subkey"},      bus_if.subkey,      0);
    check({tag, "_last_round"},  bus_if.last_round,  0);
    check({tag, "_done_valid"},  bus_if.done_valid,  0);
    check({tag, "_busy"},        bus_if.busy,        0);
  endtask

  // One full block from IDLE: accept, 16 rounds (with optional stalls), DONE with backpressure, back to IDLE.
  task automatic run_block(input logic [63:0] k, input logic dec, input int stall_at, input int stall_len,
                           input bit rnd_stall, input int ready_delay);
    int  k_idx, cyc, left;
    bit  stall_now;
    compute_model(k, dec);
    bus_if.key         = k;
    bus_if.decrypt     = dec;
    bus_if.start_valid = 1'b1;
    bus_if.done_ready  = 1'b0;
    #1;
    check("accept_start_ready", bus_if.start_ready, 1);
    check("accept_block_load",  bus_if.block_load,  1);
    step();
    k_idx = 0;
    cyc   = 0;
    left  = stall_len;
    while (k_idx < 16 && cyc < 64) begin
      bus_if.key         = {$urandom, $urandom};
      bus_if.decrypt     = 1'($urandom_range(1));
      bus_if.start_valid = 1'($urandom_range(1));
      bus_if.done_ready  = 1'($urandom_range(1));
      stall_now = 1'b0;
`ifdef DES_ROUND_STALL_EN
      if (k_idx == stall_at && left > 0) begin
        stall_now = 1'b1;
        left--;
      end else if (rnd_stall && $urandom_range(3) == 0) begin
        stall_now = 1'b1;
      end
      bus_if.round_stall = stall_now;
`endif
      #1;
      cyc++;
      check("round_start_ready", bus_if.start_ready, 0);
      check("round_block_load",  bus_if.block_load,  0);
      check("round_busy",        bus_if.busy,        1);
      check("round_done_valid",  bus_if.done_valid,  0);
      if (stall_now) begin
        check("stall_round_en", bus_if.round_en, 0);
        check("stall_subkey",   bus_if.subkey,   0);
      end else begin
        check("round_en",    bus_if.round_en,   1);
        check("round_idx",   bus_if.round_idx,  k_idx);
        check("subkey",      bus_if.subkey,     exp_sk[k_idx]);
        check("last_round",  bus_if.last_round, k_idx == 15);
        if (const_vld[k_idx]) check("spec_subkey", bus_if.subkey, const_sk[k_idx]);
        k_idx++;
      end
      step();
    end
    check("round_budget", k_idx, 16);
    bus_if.start_valid = 1'b0;
    bus_if.done_ready  = (ready_delay == 0);
`ifdef DES_ROUND_STALL_EN
    bus_if.round_stall = 1'($urandom_range(1));
`endif
    #1;
    check("done_valid",       bus_if.done_valid,  1);
    check("done_round_en",    bus_if.round_en,    0);
    check("done_subkey",      bus_if.subkey,      0);
    check("done_busy",        bus_if.busy,        1);
    check("done_start_ready", bus_if.start_ready, 0);
    for (int i = 0; i < ready_delay; i++) begin
      step();
      bus_if.done_ready  = (i == ready_delay - 1);
      bus_if.start_valid = (i == 1);
`ifdef DES_ROUND_STALL_EN
      bus_if.round_stall = 1'($urandom_range(1));
`endif
      #1;
      check("hold_done_valid",  bus_if.done_valid,  1);
      check("hold_start_ready", bus_if.start_ready, 0);
      check("hold_block_load",  bus_if.block_load,  0);
      check("hold_round_en",    bus_if.round_en,    0);
    end
    step();
    bus_if.done_ready  = 1'b0;
    bus_if.start_valid = 1'b0;
`ifdef DES_ROUND_STALL_EN
    bus_if.round_stall = 1'b0;
`endif
    #1;
    check("idle_done_valid",  bus_if.done_valid,  0);
    check("idle_busy",        bus_if.busy,        0);
    check("idle_start_ready", bus_if.start_ready, 1);
  endtask

  initial begin
    int last_acc, rounds;
    logic [63:0] rk;
    logic        rd;

    rst_n              = 1'b0;
    bus_if.start_valid = 1'b1;
    bus_if.key         = SPEC_KEY;
    bus_if.decrypt     = 1'b0;
    bus_if.done_ready  = 1'b0;
`ifdef DES_ROUND_STALL_EN
    bus_if.round_stall = 1'b0;
`endif
    clear_consts();
    repeat (3) step();
    #1;
    check_all_zero("reset");
    bus_if.start_valid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check("release_start_ready_pre", bus_if.start_ready, 0);
    step();
    #1;
    check("release_start_ready_post", bus_if.start_ready, 1);

    // Encrypt with the reference key and its published subkeys.
    const_sk[0]  = 48'h1B02EFFC7072; const_vld[0]  = 1'b1;
    const_sk[1]  = 48'h79AED9DBC9E5; const_vld[1]  = 1'b1;
    const_sk[15] = 48'hCB3D8B0E17F5; const_vld[15] = 1'b1;
    run_block(SPEC_KEY, 1'b0, -1, 0, 1'b0, 0);
    clear_consts();

    // Decrypt: reverse order.
    const_sk[0]  = 48'hCB3D8B0E17F5; const_vld[0]  = 1'b1;
    const_sk[14] = 48'h79AED9DBC9E5; const_vld[14] = 1'b1;
    const_sk[15] = 48'h1B02EFFC7072; const_vld[15] = 1'b1;
    run_block(SPEC_KEY, 1'b1, -1, 0, 1'b0, 0);
    clear_consts();

    // Backpressure on done, then an immediate new acceptance.
    run_block(SPEC_KEY, 1'b0, -1, 0, 1'b0, 5);
    run_block(64'h0E329232EA6D0D73, 1'b1, -1, 0, 1'b0, 0);

    // Asynchronous reset during round 7.
    bus_if.key         = SPEC_KEY;
    bus_if.decrypt     = 1'b0;
    bus_if.start_valid = 1'b1;
    step();
    bus_if.start_valid = 1'b0;
    repeat (7) step();
    #1;
    check("midrun_idx7", bus_if.round_idx, 7);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    step();
    rst_n = 1'b1;
    #1;
    check("midrun_release_pre", bus_if.start_ready, 0);
    step();
    #1;
    check("midrun_release_post", bus_if.start_ready, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      #1;
      check("midrun_no_done", bus_if.done_valid, 0);
    end
    const_sk[0]  = 48'h1B02EFFC7072; const_vld[0]  = 1'b1;
    const_sk[15] = 48'hCB3D8B0E17F5; const_vld[15] = 1'b1;
    run_block(SPEC_KEY, 1'b0, -1, 0, 1'b0, 0);
    clear_consts();

`ifdef DES_ROUND_STALL_EN
    // Stall at round 3 for two cycles: done arrives at T+19.
    run_block(SPEC_KEY, 1'b0, 3, 2, 1'b0, 0);
`endif

    // Back-to-back blocks with start_valid and done_ready held high.
    rk = {$urandom, $urandom};
    rd = 1'($urandom_range(1));
    compute_model(rk, rd);
    bus_if.key         = rk;
    bus_if.decrypt     = rd;
    bus_if.start_valid = 1'b1;
    bus_if.done_ready  = 1'b1;
    last_acc = -1;
    rounds   = 0;
    for (int cyc = 0; cyc < 56; cyc++) begin
      #1;
      if (bus_if.block_load) begin
        if (last_acc >= 0) begin
          check("b2b_gap",    cyc - last_acc, 18);
          check("b2b_rounds", rounds, 16);
        end
        last_acc = cyc;
        rounds   = 0;
      end
      if (bus_if.round_en) begin
        check("b2b_subkey", bus_if.subkey, exp_sk[bus_if.round_idx]);
        rounds++;
      end
      step();
    end
    check("b2b_last_acc", last_acc, 54);
    bus_if.start_valid = 1'b0;
    repeat (20) step();
    bus_if.done_ready = 1'b0;
    step();
    #1;
    check("b2b_drain_idle", bus_if.start_ready, 1);

    // Random keys, directions, stalls and done backpressure.
    for (int b = 0; b < 10; b++) begin
      run_block({$urandom, $urandom}, 1'($urandom_range(1)), -1, 0, 1'b1, $urandom_range(3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
